logaritm_discret: RTL and testbench
===================================

# logaritm_discret

Sequential integer-logarithm unit, the inverse of the team's power block. Given a value X and a base M, it finds the largest N with M^N <= X, using repeated multiplication from 1. It also reports whether X is an exact power of M. It uses the same start/ack handshake as the power block, so a test harness can chain the two: X = M^N in, N out.

## Interface
- WX, 16, width of operand X and of the internal running power P
- WM, 4, width of base M
- WN, 4, width of result N (max reachable N is 15, at M=2)
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- X  in  WX  value whose logarithm is taken; sampled with start
- M  in  WM  base; sampled with start
- ack  out  1  one-cycle done pulse; reset 0
- busy  out  1  high from accepted start until ack; reset 0
- N  out  WN  floor(log_M X); held until next accepted start; reset 0
- exact  out  1  1 when M^N == X; held; reset 0
- err  out  1  1 for illegal operands; held; reset 0
- R  out  WX  X - M^N; present only with LOGARITM_REST_EN; reset 0

## Operation
- States: IDLE, CALC, DONE. Reset enters IDLE and clears all outputs and internal registers (Xr, Mr, P).
- IDLE with start=1:
  - Latch Xr<=X and Mr<=M; set P<=1, N<=0, exact<=0, err<=0, busy<=1.
  - If M<2 or X==0: set err<=1, N<=0, busy<=0, ack<=1, and go to DONE.
  - Otherwise go to CALC.
- CALC, each edge:
  - Form prod = P*Mr at WX+WM bits, with no truncation.
  - If prod <= Xr: P<=prod[WX-1:0], N<=N+1, stay in CALC.
  - Else: exact<=(P==Xr), ack<=1, busy<=0, go to DONE.
- DONE: ack<=0, go to IDLE on the next edge.
- start is ignored in CALC and DONE. A start held high across DONE is accepted on the first IDLE edge.
- The comparison uses the full-width product, so prod can never wrap below Xr.

## Timing
- Edge 0 accepts start. Edges 1..N perform the steps. Edge N+1 terminates, and ack is high for the cycle after edge N+1.
- Latency from the accepting edge to ack high is N+1 cycles. Worst case is 16 cycles (M=2, X>=32768).
- On the err path, ack is high for the cycle after edge 0.
- N, exact, err and R are valid while ack is high and remain stable until the next accepted start.
- Back-to-back throughput is one result per N+3 cycles.
- Reset asserted mid-operation forces IDLE asynchronously. ack and busy drop immediately, and no partial result is kept.

## Configuration
- LOGARITM_REST_EN defined:
  - Port R exists.
  - R<=Xr-P is registered on the terminating CALC edge.
  - R<=0 on the err path.
- LOGARITM_REST_EN undefined:
  - Port R and its subtractor are absent.
  - All other behaviour is identical.

## Structure
- Shared package `logaritm_pkg` holds:
  - the state typedef (IDLE=0, CALC=1, DONE=2, 2-bit encoding)
  - the default widths WX, WM, WN as constants
  - the constant BASE_MIN=2
- One sub-module, `pas_log`. It is combinational: inputs P and Mr, outputs prod and le = (prod <= Xr). The FSM in logaritm_discret instantiates it once.

## Test plan
- X=9, M=3: N=2, exact=1, err=0, R=0, ack 3 cycles after the accepting edge, busy high for exactly those 3 cycles.
- X=10, M=3: N=2, exact=0, R=1.
- X=65535, M=2: N=15, exact=0, R=32767, latency 16. X=1, M=5: N=0, exact=1, latency 1.
- M=1, X=7 and separately M=5, X=0: err=1, N=0, ack 1 cycle after accept. Then X=8, M=2: err cleared, N=3, exact=1.
- X=4096, M=4 started; start re-pulsed with X=5, M=2 while busy: the re-pulse is ignored, result N=6, exact=1.
- X=4096, M=2 started; Rst_n low during CALC: outputs 0 at once. After release, X=27, M=3: N=3, exact=1.

Source files
------------

// File: rtl/logaritm_pkg.sv
// logaritm_pkg: shared types and constants for the integer-logarithm unit.
//   state_t  : FSM encoding (IDLE=0, CALC=1, DONE=2)
//   WX/WM/WN : default widths of X (and running power P), base M, result N
//   BASE_MIN : smallest legal base
package logaritm_pkg;

    localparam int WX = 16;
    localparam int WM = 4;
    localparam int WN = 4;

    localparam logic [WM-1:0] BASE_MIN = 4'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/logaritm_discret_if.sv
// logaritm_discret_if: start/ack request bus of the integer-logarithm unit.
//   master : drives start, X, M; observes ack, busy, N, exact, err (and R)
//   slave  : the logarithm unit itself
// R is present only when LOGARITM_REST_EN is defined.
interface logaritm_discret_if;
    import logaritm_pkg::*;

    logic          start;
    logic [WX-1:0] X;
    logic [WM-1:0] M;
    logic          ack;
    logic          busy;
    logic [WN-1:0] N;
    logic          exact;
    logic          err;
`ifdef LOGARITM_REST_EN
    logic [WX-1:0] R;

    modport master (output start, X, M, input ack, busy, N, exact, err, R);
    modport slave  (input start, X, M, output ack, busy, N, exact, err, R);
`else
    modport master (output start, X, M, input ack, busy, N, exact, err);
    modport slave  (input start, X, M, output ack, busy, N, exact, err);
`endif

endinterface

// File: rtl/pas_log.sv
// pas_log: one combinational step of the logarithm search.
//   p, mr : running power and latched base
//   xr    : latched operand
//   prod  : p*mr at full WX+WM width (never wraps)
//   le    : prod <= xr, i.e. one more multiplication still fits
module pas_log
    import logaritm_pkg::*;
(
    input  logic [WX-1:0]    p,
    input  logic [WM-1:0]    mr,
    input  logic [WX-1:0]    xr,
    output logic [WX+WM-1:0] prod,
    output logic             le
);

    assign prod = {{WM{1'b0}}, p} * {{WX{1'b0}}, mr};
    assign le   = (prod <= {{WM{1'b0}}, xr});

endmodule

// File: rtl/logaritm_discret.sv
// logaritm_discret: sequential floor(log_M X) by repeated multiplication from 1.
//   Clk, Rst_n : clock, asynchronous active-low reset
//   bus        : slave side of logaritm_discret_if (start/X/M in,
//                ack/busy/N/exact/err[/R] out)
// Optional: LOGARITM_REST_EN adds the remainder output R = X - M^N.
module logaritm_discret
    import logaritm_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst_n,
    logaritm_discret_if.slave   bus
);

    state_t          state, state_d;
    logic [WX-1:0]   xr, xr_d;
    logic [WM-1:0]   mr, mr_d;
    logic [WX-1:0]   p, p_d;
    logic [WN-1:0]   n, n_d;
    logic            exact, exact_d;
    logic            err, err_d;
    logic            ack, ack_d;
    logic            busy, busy_d;
    logic [WX+WM-1:0] prod;
    logic            le;
`ifdef LOGARITM_REST_EN
    logic [WX-1:0]   r, r_d;
`endif

    pas_log u_pas (
        .p    (p),
        .mr   (mr),
        .xr   (xr),
        .prod (prod),
        .le   (le)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            xr    <= '0;
            mr    <= '0;
            p     <= '0;
            n     <= '0;
            exact <= 1'b0;
            err   <= 1'b0;
            ack   <= 1'b0;
            busy  <= 1'b0;
`ifdef LOGARITM_REST_EN
            r     <= '0;
`endif
        end else begin
            state <= state_d;
            xr    <= xr_d;
            mr    <= mr_d;
            p     <= p_d;
            n     <= n_d;
            exact <= exact_d;
            err   <= err_d;
            ack   <= ack_d;
            busy  <= busy_d;
`ifdef LOGARITM_REST_EN
            r     <= r_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        xr_d    = xr;
        mr_d    = mr;
        p_d     = p;
        n_d     = n;
        exact_d = exact;
        err_d   = err;
        ack_d   = 1'b0;     // ack is a single-cycle pulse
        busy_d  = busy;
`ifdef LOGARITM_REST_EN
        r_d     = r;
`endif
        case (state)
            IDLE: begin
                if (bus.start) begin
                    xr_d    = bus.X;
                    mr_d    = bus.M;
                    p_d     = {{(WX-1){1'b0}}, 1'b1};
                    n_d     = '0;
                    exact_d = 1'b0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    // Base 0/1 never grows and log of 0 is undefined:
                    // report immediately without entering CALC.
                    if (bus.M < BASE_MIN || bus.X == '0) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        ack_d   = 1'b1;
`ifdef LOGARITM_REST_EN
                        r_d     = '0;
`endif
                        state_d = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (le) begin
                    p_d = prod[WX-1:0];
                    n_d = n + 1'b1;
                end else begin
                    exact_d = (p == xr);
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
`ifdef LOGARITM_REST_EN
                    r_d     = xr - p;
`endif
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack   = ack;
    assign bus.busy  = busy;
    assign bus.N     = n;
    assign bus.exact = exact;
    assign bus.err   = err;
`ifdef LOGARITM_REST_EN
    assign bus.R     = r;
`endif

endmodule

// File: tb/tb_logaritm_discret.sv
// tb_logaritm_discret: directed + randomized check of logaritm_discret
// against a reference model built from integer exponentiation.
module tb_logaritm_discret;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    logaritm_discret_if bus ();

    logaritm_discret dut (
        .Clk   (clk),
        .Rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Largest n with m**n <= x, computed by direct exponentiation.
    function automatic void model(input int x, input int m, output int n,
                                  output int ex, output int er, output int r);
        longint pw;
        n = 0; ex = 0; r = 0;
        er = (m < 2 || x == 0) ? 1 : 0;
        if (er == 0) begin
            for (int k = 0; k <= 16; k++) begin
                pw = longint'(m) ** k;
                if (pw <= longint'(x)) n = k;
            end
            pw = longint'(m) ** n;
            ex = (pw == longint'(x)) ? 1 : 0;
            r  = int'(longint'(x) - pw);
        end
    endfunction

    task automatic run_op(input int x, input int m, input bit repulse);
        int en, eex, eer, er_r, lat, bcnt, elat;
        model(x, m, en, eex, eer, er_r);
        @(negedge clk);
        bus.start = 1'b1;
        bus.X     = x[15:0];
        bus.M     = m[3:0];
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 0; bcnt = 0;
        while (bus.ack !== 1'b1 && lat < 40) begin
            if (bus.busy === 1'b1) bcnt++;
            if (repulse && lat == 2) begin
                bus.start = 1'b1; bus.X = 16'd5; bus.M = 4'd2;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.start = 1'b0;
        elat = eer ? 0 : en + 1;
        chk($sformatf("latency x=%0d m=%0d", x, m), lat, elat);
        chk($sformatf("busy_cycles x=%0d m=%0d", x, m), bcnt, elat);
        chk($sformatf("busy_at_ack x=%0d m=%0d", x, m), bus.busy, 0);
        chk($sformatf("N x=%0d m=%0d", x, m), bus.N, en);
        chk($sformatf("exact x=%0d m=%0d", x, m), bus.exact, eex);
        chk($sformatf("err x=%0d m=%0d", x, m), bus.err, eer);
`ifdef LOGARITM_REST_EN
        chk($sformatf("R x=%0d m=%0d", x, m), bus.R, er_r);
`endif
        @(posedge clk); #1;
        chk($sformatf("ack_pulse x=%0d m=%0d", x, m), bus.ack, 0);
        chk($sformatf("N_held x=%0d m=%0d", x, m), bus.N, en);
    endtask

    initial begin
        int x, m, mode, k, pw;
        bus.start = 1'b0;
        bus.X     = '0;
        bus.M     = '0;
        #12;
        chk("rst_ack",   bus.ack,   0);
        chk("rst_busy",  bus.busy,  0);
        chk("rst_N",     bus.N,     0);
        chk("rst_exact", bus.exact, 0);
        chk("rst_err",   bus.err,   0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(9, 3, 1'b0);
        run_op(10, 3, 1'b0);
        run_op(65535, 2, 1'b0);
        run_op(1, 5, 1'b0);
        run_op(7, 1, 1'b0);
        run_op(0, 5, 1'b0);
        run_op(8, 2, 1'b0);
        run_op(4096, 4, 1'b1);
        run_op(32768, 2, 1'b0);
        run_op(65535, 15, 1'b0);

        // Reset in the middle of a calculation.
        @(negedge clk);
        bus.start = 1'b1; bus.X = 16'd4096; bus.M = 4'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_before_rst", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ack",   bus.ack,   0);
        chk("midrst_busy",  bus.busy,  0);
        chk("midrst_N",     bus.N,     0);
        chk("midrst_exact", bus.exact, 0);
        chk("midrst_err",   bus.err,   0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(27, 3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            m    = int'($urandom_range(0, 15));
            mode = int'($urandom_range(0, 3));
            case (mode)
                0: x = int'($urandom_range(0, 65535));
                1: x = int'($urandom_range(0, 300));
                default: begin
                    pw = 1;
                    k  = int'($urandom_range(0, 15));
                    if (m >= 2) begin
                        for (int j = 0; j < k; j++)
                            if (pw * m <= 65535) pw = pw * m;
                    end
                    x = (mode == 3 && pw < 65535) ? pw + 1 : pw;
                end
            endcase
            run_op(x, m, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
